// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_unit_pkg: shared types and constants of the fetch stage
// Revision: 1.0
// ------------------------------------------------------------------
package instr_fetch_unit_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'b00,
      FETCH_WAIT  = 2'b01,
      FETCH_DRAIN = 2'b10
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] pc;
      logic [INSTR_WIDTH-1:0] word;
   } fetch_entry_t;

   function automatic logic [INSTR_WIDTH-1:0] word_align(input logic [INSTR_WIDTH-1:0] addr);
      return {addr[INSTR_WIDTH-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_unit_if: instruction memory, redirect and decode links
// Revision: 1.0
// ------------------------------------------------------------------
interface instr_fetch_unit_if;
   import instr_fetch_unit_pkg::*;

   logic                   imem_req;
   logic [INSTR_WIDTH-1:0] imem_addr;
   logic                   imem_ack;
   logic [INSTR_WIDTH-1:0] imem_data;
   logic                   redirect;
   logic [INSTR_WIDTH-1:0] redirect_pc;
   logic                   instr_valid;
   logic [INSTR_WIDTH-1:0] instr;
   logic [INSTR_WIDTH-1:0] instr_pc;
   logic                   instr_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      input  redirect, redirect_pc,
      output instr_valid, instr, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      output redirect, redirect_pc,
      input  instr_valid, instr, instr_pc,
      output instr_ready
   );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_fifo: DEPTH x {pc, word} synchronous FIFO with flush
// Revision: 1.0
// ------------------------------------------------------------------
module instr_fetch_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   input  wire logic                     flush,
   input  wire logic                     push,
   input  wire fetch_entry_t             push_data,
   input  wire logic                     pop,
   output fetch_entry_t                  head,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   // Flush wins over both ports so a redirect cycle never moves data.
   assign w_push = push & ~flush & (r_count != C_FULL);
   assign w_pop  = pop  & ~flush & (r_count != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_unit: PC owner, single-outstanding imem fetch, decode FIFO
// Revision: 1.0
// ------------------------------------------------------------------
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [INSTR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
   parameter int                     DEPTH    = 2
) (
   input  wire logic           clk,
   input  wire logic           reset,
   instr_fetch_unit_if.master  bus
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [INSTR_WIDTH-1:0] C_PC_STEP = 32'd4;

   fetch_state_t           r_state;
   fetch_state_t           w_state_nxt;
   logic [INSTR_WIDTH-1:0] r_fetch_pc;
   logic [INSTR_WIDTH-1:0] w_fetch_pc_nxt;
   logic [INSTR_WIDTH-1:0] w_redirect_pc;
   logic                   w_req;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_space;
   logic                   w_valid;
   logic [AW:0]            w_count;
   fetch_entry_t           w_head;
   fetch_entry_t           w_push_data;
   logic                   w_unused_pc_bits;

   assign w_redirect_pc    = word_align(bus.redirect_pc);
   assign w_unused_pc_bits = ^bus.redirect_pc[1:0];

   // The outstanding fetch already owns a slot, so count alone gates issue.
   assign w_space = (w_count < C_DEPTH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= FETCH_IDLE;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_req          = 1'b0;
      w_push         = 1'b0;
      case (r_state)
         FETCH_IDLE: begin
            if (bus.redirect) begin
               w_fetch_pc_nxt = w_redirect_pc;
            end else if (w_space) begin
               w_req          = 1'b1;
               w_fetch_pc_nxt = r_fetch_pc + C_PC_STEP;
               w_state_nxt    = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (bus.redirect) begin
               w_fetch_pc_nxt = w_redirect_pc;
               w_state_nxt    = bus.imem_ack ? FETCH_IDLE : FETCH_DRAIN;
            end else if (bus.imem_ack) begin
               w_push      = 1'b1;
               w_state_nxt = FETCH_IDLE;
            end
         end
         FETCH_DRAIN: begin
            // An ack here pays off the abandoned fetch even if another redirect lands.
            if (bus.redirect) w_fetch_pc_nxt = w_redirect_pc;
            if (bus.imem_ack) w_state_nxt = FETCH_IDLE;
         end
         default: begin
            w_state_nxt = FETCH_IDLE;
         end
      endcase
   end

   // fetch_pc has already advanced past the word being returned.
   assign w_push_data.pc   = r_fetch_pc - C_PC_STEP;
   assign w_push_data.word = bus.imem_data;

   assign w_valid = (w_count != '0) & ~bus.redirect;
   assign w_pop   = w_valid & bus.instr_ready;

   instr_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.redirect),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count)
   );

   assign bus.imem_req    = w_req & ~reset;
   assign bus.imem_addr   = r_fetch_pc;
   assign bus.instr_valid = w_valid;
   assign bus.instr       = w_head.word;
   assign bus.instr_pc    = w_head.pc;

endmodule
`default_nettype wire
